// File: rtl/addr_gen_fft_iter_inplace_pkg.sv
// Shared FFT helpers: index widths and the in-place
// radix-2 DIT butterfly address function.
package addr_gen_fft_iter_inplace_pkg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] tw;
  } fft_addr_t;

  function automatic int unsigned addr_wl(
    input int unsigned butt_wl
  );
    return butt_wl + 1;
  endfunction

  function automatic fft_addr_t fft_addr(
    input int unsigned b,
    input int unsigned l,
    input int unsigned layers
  );
    int unsigned j;
    int unsigned g;
    fft_addr_t r;
    j    = b & ((32'd1 << l) - 32'd1);
    g    = b >> l;
    r.a  = (g << (l + 1)) + j;
    r.b  = r.a + (32'd1 << l);
    r.tw = j << (layers - 1 - l);
    return r;
  endfunction

endpackage

// File: rtl/fft_inplace_addr_calc.sv
// Combinational (butterfly, layer) -> (A, B, twiddle)
// mapping, shared with the loader/unloader paths.
module fft_inplace_addr_calc
  import addr_gen_fft_iter_inplace_pkg::*;
#(
  parameter int LAYERS = 3,
  parameter int ButtWL = 2,
  parameter int LayWL  = 2,
  parameter int AddrWL = ButtWL + 1
) (
  input  logic [ButtWL-1:0] b,
  input  logic [LayWL-1:0]  l,
  output logic [AddrWL-1:0] a_addr,
  output logic [AddrWL-1:0] b_addr,
  output logic [ButtWL-1:0] tw_addr
);

  fft_addr_t r;
  logic      unused_hi;

  always_comb begin
    r       = fft_addr(32'(b), 32'(l), LAYERS);
    a_addr  = r.a[AddrWL-1:0];
    b_addr  = r.b[AddrWL-1:0];
    tw_addr = r.tw[ButtWL-1:0];
  end

  assign unused_hi = ^{r.a[31:AddrWL],
                       r.b[31:AddrWL],
                       r.tw[31:ButtWL]};

endmodule

// File: rtl/addr_gen_fft_iter_inplace.sv
// Tracks butterfly/layer position of an in-place FFT and
// drives RAM/twiddle addresses from control-unit strobes.
module addr_gen_fft_iter_inplace
  import addr_gen_fft_iter_inplace_pkg::*;
#(
  parameter int LAYERS      = 3,
  parameter int BUTTERFLYES = 4,
  parameter int LayWL       = 2,
  parameter int ButtWL      = 2,
  localparam int AddrWL     = ButtWL + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              START,
  input  logic              BUT_STROB,
  input  logic              ADDR_EN,
  input  logic              LAY_EN,
  output logic [AddrWL-1:0] RD_ADDR_A,
  output logic [AddrWL-1:0] RD_ADDR_B,
  output logic [ButtWL-1:0] TW_ADDR,
  output logic              RD_VALID,
  output logic [AddrWL-1:0] WR_ADDR_A,
  output logic [AddrWL-1:0] WR_ADDR_B,
  output logic              WR_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              SEQ_ERR
);

  logic [ButtWL-1:0] b_q;
  logic [LayWL-1:0]  l_q;
  logic              pending_q;
  logic [AddrWL-1:0] a_c;
  logic [AddrWL-1:0] bb_c;
  logic [ButtWL-1:0] tw_c;
  logic              last_b;
  logic              last_l;
  logic              lay_ok;
  logic              viol;

  fft_inplace_addr_calc #(
    .LAYERS (LAYERS),
    .ButtWL (ButtWL),
    .LayWL  (LayWL),
    .AddrWL (AddrWL)
  ) u_calc (
    .b       (b_q),
    .l       (l_q),
    .a_addr  (a_c),
    .b_addr  (bb_c),
    .tw_addr (tw_c)
  );

  always_comb begin
    last_b = (b_q == ButtWL'(BUTTERFLYES - 1));
    last_l = (l_q == LayWL'(LAYERS - 1));
    lay_ok = ADDR_EN & pending_q & last_b & ~last_l;
    viol   = (BUT_STROB & pending_q)
           | (ADDR_EN & ~pending_q)
           | (BUT_STROB & ADDR_EN)
           | (LAY_EN & ~lay_ok);
  end

  assign WR_EN = ADDR_EN & EN & pending_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      b_q       <= '0;
      l_q       <= '0;
      pending_q <= 1'b0;
      RD_ADDR_A <= '0;
      RD_ADDR_B <= '0;
      TW_ADDR   <= '0;
      WR_ADDR_A <= '0;
      WR_ADDR_B <= '0;
      RD_VALID  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      SEQ_ERR   <= 1'b0;
    end else if (EN) begin
      RD_VALID <= 1'b0;
      DONE     <= 1'b0;
      if (START) begin
        b_q       <= '0;
        l_q       <= '0;
        pending_q <= 1'b0;
        SEQ_ERR   <= 1'b0;
        BUSY      <= 1'b1;
      end else if (BUSY) begin
        // ADDR_EN wins over a coincident BUT_STROB
        if (ADDR_EN) begin
          if (pending_q) begin
            pending_q <= 1'b0;
            if (last_b) begin
              b_q <= '0;
              if (last_l) begin
                l_q  <= '0;
                BUSY <= 1'b0;
                DONE <= 1'b1;
              end else begin
                l_q <= l_q + 1'b1;
              end
            end else begin
              b_q <= b_q + 1'b1;
            end
          end
        end else if (BUT_STROB) begin
          RD_ADDR_A <= a_c;
          RD_ADDR_B <= bb_c;
          TW_ADDR   <= tw_c;
          WR_ADDR_A <= a_c;
          WR_ADDR_B <= bb_c;
          pending_q <= 1'b1;
          RD_VALID  <= 1'b1;
        end
        if (viol) begin
          SEQ_ERR <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_addr_gen_fft_iter_inplace.sv
// Directed table-driven bench for the in-place FFT
// address generator (LAYERS=3, BUTTERFLYES=4).
module tb_addr_gen_fft_iter_inplace;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic       START;
  logic       BUT_STROB;
  logic       ADDR_EN;
  logic       LAY_EN;
  logic [2:0] RD_ADDR_A;
  logic [2:0] RD_ADDR_B;
  logic [1:0] TW_ADDR;
  logic       RD_VALID;
  logic [2:0] WR_ADDR_A;
  logic [2:0] WR_ADDR_B;
  logic       WR_EN;
  logic       BUSY;
  logic       DONE;
  logic       SEQ_ERR;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int a;
    int b;
    int tw;
    bit lay;
  } vec_t;

  vec_t tbl [12];

  addr_gen_fft_iter_inplace #(
    .LAYERS      (3),
    .BUTTERFLYES (4),
    .LayWL       (2),
    .ButtWL      (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .START     (START),
    .BUT_STROB (BUT_STROB),
    .ADDR_EN   (ADDR_EN),
    .LAY_EN    (LAY_EN),
    .RD_ADDR_A (RD_ADDR_A),
    .RD_ADDR_B (RD_ADDR_B),
    .TW_ADDR   (TW_ADDR),
    .RD_VALID  (RD_VALID),
    .WR_ADDR_A (WR_ADDR_A),
    .WR_ADDR_B (WR_ADDR_B),
    .WR_EN     (WR_EN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .SEQ_ERR   (SEQ_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 32'({RD_ADDR_A, RD_ADDR_B, TW_ADDR,
                 RD_VALID, WR_ADDR_A, WR_ADDR_B,
                 WR_EN, BUSY, DONE, SEQ_ERR}), 0);
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("start_busy", 32'(BUSY), 1);
  endtask

  // read strobe, one gap cycle, then write-back
  task automatic bfly(input vec_t v, input bit gate);
    if (gate) begin
      EN = 1'b0; BUT_STROB = 1'b1;
      tick();
      EN = 1'b1;
    end
    BUT_STROB = 1'b1;
    tick();
    BUT_STROB = 1'b0;
    chk("rd_valid_hi", 32'(RD_VALID), 1);
    chk("rd_a", 32'(RD_ADDR_A), v.a);
    chk("rd_b", 32'(RD_ADDR_B), v.b);
    chk("tw", 32'(TW_ADDR), v.tw);
    tick();
    chk("rd_valid_lo", 32'(RD_VALID), 0);
    if (gate) begin
      EN = 1'b0; ADDR_EN = 1'b1;
      #3;
      chk("wr_en_gated", 32'(WR_EN), 0);
      tick();
      EN = 1'b1;
    end
    ADDR_EN = 1'b1; LAY_EN = v.lay;
    #3;
    chk("wr_en", 32'(WR_EN), 1);
    chk("wr_a", 32'(WR_ADDR_A), v.a);
    chk("wr_b", 32'(WR_ADDR_B), v.b);
    tick();
    ADDR_EN = 1'b0; LAY_EN = 1'b0;
  endtask

  task automatic chk_done();
    chk("done_pulse", 32'(DONE), 1);
    chk("done_busy", 32'(BUSY), 0);
    chk("done_err", 32'(SEQ_ERR), 0);
    tick();
    chk("done_clear", 32'(DONE), 0);
  endtask

  initial begin
    tbl[0]  = '{0, 1, 0, 1'b0};
    tbl[1]  = '{2, 3, 0, 1'b0};
    tbl[2]  = '{4, 5, 0, 1'b0};
    tbl[3]  = '{6, 7, 0, 1'b1};
    tbl[4]  = '{0, 2, 0, 1'b0};
    tbl[5]  = '{1, 3, 2, 1'b0};
    tbl[6]  = '{4, 6, 0, 1'b0};
    tbl[7]  = '{5, 7, 2, 1'b1};
    tbl[8]  = '{0, 4, 0, 1'b0};
    tbl[9]  = '{1, 5, 1, 1'b0};
    tbl[10] = '{2, 6, 2, 1'b0};
    tbl[11] = '{3, 7, 3, 1'b0};

    RST = 1'b1; EN = 1'b1; START = 1'b0;
    BUT_STROB = 1'b0; ADDR_EN = 1'b0; LAY_EN = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    chk_zero("reset_outs");

    // full ungated transform
    do_start();
    for (int i = 0; i < 12; i++) bfly(tbl[i], 1'b0);
    chk_done();

    // EN gated every other cycle
    do_start();
    for (int i = 0; i < 12; i++) bfly(tbl[i], 1'b1);
    chk_done();

    // ADDR_EN before any BUT_STROB
    do_start();
    ADDR_EN = 1'b1;
    #3;
    chk("early_wr_en", 32'(WR_EN), 0);
    tick();
    ADDR_EN = 1'b0;
    chk("early_err", 32'(SEQ_ERR), 1);
    bfly(tbl[0], 1'b0);
    chk("err_sticky", 32'(SEQ_ERR), 1);

    // restart at layer 1, b=2
    do_start();
    chk("restart_clr", 32'(SEQ_ERR), 0);
    for (int i = 0; i < 6; i++) bfly(tbl[i], 1'b0);
    ADDR_EN = 1'b1;
    tick();
    ADDR_EN = 1'b0;
    chk("mid_err", 32'(SEQ_ERR), 1);
    do_start();
    chk("restart_clr2", 32'(SEQ_ERR), 0);
    bfly(tbl[0], 1'b0);

    // reset during layer 2
    do_start();
    for (int i = 0; i < 9; i++) bfly(tbl[i], 1'b0);
    BUT_STROB = 1'b1;
    tick();
    BUT_STROB = 1'b0;
    chk("l2_rd_a", 32'(RD_ADDR_A), 1);
    chk("l2_tw", 32'(TW_ADDR), 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_zero("midrst_outs");
    BUT_STROB = 1'b1;
    tick();
    BUT_STROB = 1'b0;
    chk_zero("idle_strobe");

    // LAY_EN at b=1 is misplaced
    do_start();
    bfly(tbl[0], 1'b0);
    BUT_STROB = 1'b1;
    tick();
    BUT_STROB = 1'b0;
    tick();
    ADDR_EN = 1'b1; LAY_EN = 1'b1;
    tick();
    ADDR_EN = 1'b0; LAY_EN = 1'b0;
    chk("lay_err", 32'(SEQ_ERR), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
